cla_seq_adder: RTL and testbench

Byte-serial multi-precision adder/subtractor controller. It accepts two `8*NBYTES`-bit operands over a valid/ready handshake and sequences a single `cla8` 8-bit carry-lookahead slice across the bytes, least-significant byte first, chaining the carry through a register. It returns the sum, carry-out and signed overflow over a second valid/ready handshake. It is the shared wide-arithmetic engine for blocks that cannot afford a full-width lookahead adder.

---
 rtl/cla_seq_adder.sv | 164 ++++++++++++++++
 tb/tb_cla_seq_adder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: byte-serial multi-precision adder/subtractor.
// A single 8-bit carry-lookahead slice is stepped across the operand bytes,
// least-significant byte first, with the inter-byte carry held in a register.
// The only carry path per cycle is one 8-bit lookahead plus the byte mux.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both high. in_ready and out_valid are decoded from the FSM
// state only, so neither depends combinationally on any input.
module cla_seq_adder #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf,
    output logic [1:0]            o_dbg_state
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // 8-bit carry-lookahead slice: every carry is a flat sum of products of
    // generate/propagate terms and the carry-in, so no ripple through bits.
    function automatic logic [8:0] cla8(
        input logic [7:0] x,
        input logic [7:0] y,
        input logic       cin
    );
        logic [7:0] g;
        logic [7:0] p;
        logic [8:0] c;
        logic       term;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        for (int i = 1; i <= 8; i++) begin
            c[i] = 1'b0;
            // generate at bit j, propagated through bits j+1..i-1
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & p[k];
                end
                c[i] = c[i] | term;
            end
            // carry-in propagated through bits 0..i-1
            term = cin;
            for (int k = 0; k < i; k++) begin
                term = term & p[k];
            end
            c[i] = c[i] | term;
        end
        return {c[8], p ^ c[7:0]};
    endfunction

    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic          r_cy;
    logic [W-1:0]  r_opa;
    logic [W-1:0]  r_opb;
    logic [W-1:0]  r_sum;
    logic          r_cout;
    logic          r_ovf;

    logic [7:0]    w_a_byte;
    logic [7:0]    w_b_byte;
    logic [7:0]    w_cla_sum;
    logic          w_cla_cout;
    logic          w_accept;
    logic          w_step;
    logic          w_last;
    logic          w_release;
    logic          w_ovf_next;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_step    = (r_state == S_RUN);
    assign w_last    = w_step && (r_idx == LAST_IDX);
    assign w_release = (r_state == S_DONE) && out_ready;

    // Select the operand bytes addressed by the byte index.
    always_comb begin
        w_a_byte = '0;
        w_b_byte = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (r_idx == IW'(k)) begin
                w_a_byte = r_opa[8*k +: 8];
                w_b_byte = r_opb[8*k +: 8];
            end
        end
    end

    assign {w_cla_cout, w_cla_sum} = cla8(w_a_byte, w_b_byte, r_cy);

    // Signed overflow: operands agree in sign but the final MSB does not.
    assign w_ovf_next = (r_opa[W-1] == r_opb[W-1]) && (w_cla_sum[7] != r_opa[W-1]);

    // Control FSM: IDLE -> RUN (one byte per cycle) -> DONE -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept)  r_state <= S_RUN;
                S_RUN:   if (w_last)    r_state <= S_DONE;
                S_DONE:  if (w_release) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath: latch operands on accept, then write one sum byte per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= '0;
            r_cy   <= 1'b0;
            r_opa  <= '0;
            r_opb  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
            r_opa <= a;
            r_opb <= b ^ {W{sub}};
            r_cy  <= sub;
            r_idx <= '0;
            r_sum <= '0;
        end else if (w_step) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (r_idx == IW'(k)) begin
                    r_sum[8*k +: 8] <= w_cla_sum;
                end
            end
            r_cy  <= w_cla_cout;
            r_idx <= r_idx + IW'(1);
            if (w_last) begin
                r_cout <= w_cla_cout;
                r_ovf  <= w_ovf_next;
            end
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign sum         = r_sum;
    assign cout        = r_cout;
    assign ovf         = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Testbench for cla_seq_adder (NBYTES = 4): table-driven vectors, random
// vectors against an arithmetic model, backpressure and mid-run reset.
module tb_cla_seq_adder;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  // expected {cout, ovf, sum}
  logic [W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
  } vec_t;

  vec_t vecs[12];

  cla_seq_adder #(.NBYTES(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .sub        (sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .cout       (cout),
    .ovf        (ovf),
    .o_dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // reference arithmetic: plain wide add, or subtract with unsigned/signed compares
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         c;
    logic         o;
    if (!s) begin
      full = {1'b0, x} + {1'b0, y};
      r    = full[W-1:0];
      c    = full[W];
      o    = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r = x - y;
      c = (x >= y);
      o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {c, o, r};
  endfunction

  // driver: present one request at a negedge, push expectation at the accept edge
  task automatic start_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          input logic s_v, input logic [W+1:0] e);
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    a        = a_v;
    b        = b_v;
    sub      = s_v;
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    sub      = 1'($urandom_range(0, 1));
    check("in_ready_after_accept", in_ready, 0);
  endtask

  // collect one result: latency, value, optional hold under backpressure, release
  task automatic wait_result(input int hold, input logic drive_next,
                             input logic [W-1:0] na, input logic [W-1:0] nb, input logic ns);
    int           lat;
    logic [W+1:0] e;
    logic [W+1:0] held;
    lat = 0;
    while (!out_valid && lat < 50) begin
      check("in_ready_busy", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, NB);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check("sum", sum, e[W-1:0]);
    check("cout", cout, e[W+1]);
    check("ovf", ovf, e[W]);
    check("state_done", dbg_state, 2);
    held = {cout, ovf, sum};
    if (drive_next) begin
      a        = na;
      b        = nb;
      sub      = ns;
      in_valid = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_outputs", {cout, ovf, sum}, held);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_release", in_ready, 1);
    check("out_valid_after_release", out_valid, 0);
    check("sum_kept_after_release", sum, e[W-1:0]);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;

    vecs[0]  = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3]  = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[4]  = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[5]  = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0};
    vecs[6]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[7]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[8]  = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[9]  = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[10] = '{32'h0000FFFF, 32'h0000FFFF, 1'b0, 32'h0001FFFE, 1'b0, 1'b0};
    vecs[11] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b0, 1'b1};

    // reset state
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_state", dbg_state, 0);
    check("idle_out_valid", out_valid, 0);

    // directed vector table
    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub,
               {vecs[i].e_cout, vecs[i].e_ovf, vecs[i].e_sum});
      wait_result(0, 1'b0, '0, '0, 1'b0);
    end

    // random vectors against the model
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      ra = $urandom;
      rb = (i % 4 == 0) ? ~ra : $urandom;
      rs = 1'($urandom_range(0, 1));
      start_op(ra, rb, rs, model(ra, rb, rs));
      wait_result(0, 1'b0, '0, '0, 1'b0);
    end

    // backpressure: second request waits through 3 held DONE cycles
    start_op(32'h11111111, 32'h22222222, 1'b0, {1'b0, 1'b0, 32'h33333333});
    wait_result(3, 1'b1, 32'h80000000, 32'h80000000, 1'b0);
    @(posedge clk);
    exp_q.push_back({1'b1, 1'b1, 32'h00000000});
    @(negedge clk);
    in_valid = 1'b0;
    check("second_accept_after_release", in_ready, 0);
    wait_result(0, 1'b0, '0, '0, 1'b0);

    // reset during the second RUN cycle (cout/ovf are 1 from the previous op)
    start_op(32'hAABBCCDD, 32'h11223344, 1'b0, model(32'hAABBCCDD, 32'h11223344, 1'b0));
    @(posedge clk);
    @(negedge clk);
    check("midrun_state", dbg_state, 1);
    rst = 1'b1;
    #1;
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_sum", sum, 0);
    check("async_rst_cout", cout, 0);
    check("async_rst_ovf", ovf, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NB + 4; i++) begin
      @(negedge clk);
      check("no_stale_out_valid", out_valid, 0);
      check("no_stale_in_ready", in_ready, 1);
    end
    start_op(32'h12345678, 32'h11111111, 1'b0, {1'b0, 1'b0, 32'h23456789});
    wait_result(0, 1'b0, '0, '0, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
